mem_arbiter: RTL and testbench

- Shares a single memory bus between the instruction-fetch port and the load/store data port of the core.
- Sits between the core's `icache_adr_o`/`icache_instr_i` and `adr_o`/`load_data_i` side and the unified memory.
- Sequences one outstanding transaction at a time with a request/grant/response handshake.
- Data accesses have priority; a starvation guard protects fetch.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the instruction-fetch port and the
// load/store data port. One transaction is outstanding at a time:
// IDLE (arbitrate + latch) -> REQ (hold request until grant) -> RESP (wait response).
// Data requests win arbitration. When MEM_ARB_ANTI_STARVE_EN is defined, a saturating
// counter of data grants taken while fetch waits lets fetch win once it reaches STARVE_MAX.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   if_req_i/if_adr_i           fetch request and address (held until if_gnt_o)
//   if_gnt_o/if_rvalid_o        fetch grant / response valid (same-cycle as bus events)
//   if_rdata_o                  fetched instruction
//   flush_i                     redirect; drops the in-flight fetch response
//   d_req_i/d_adr_i/d_we_i      data request, address, store enable
//   d_wdata_i/d_size_i          store data, access size
//   d_gnt_o/d_rvalid_o          data grant / response valid
//   d_rdata_o                   load data
//   mem_req_o/mem_adr_o/...     registered memory request and payload
//   mem_gnt_i/mem_rvalid_i      memory grant / response valid
//   mem_rdata_i                 memory response data
module mem_arbiter #(
    parameter int unsigned XLEN = 32
`ifdef MEM_ARB_ANTI_STARVE_EN
    ,
    parameter int unsigned STARVE_MAX = 4
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,
    input  logic            flush_i,
    input  logic            d_req_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [2:0]      d_size_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic       OWNER_FETCH = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;
    localparam logic [2:0] FETCH_SIZE  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   owner_q;
    logic   drop_q;
    logic   any_req;
    logic   pick_data;
    logic   bus_gnt_c;
    logic   bus_rsp_c;

`ifdef MEM_ARB_ANTI_STARVE_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    logic [2:0] starve_q;
`endif

    // Arbitration: data first, unless fetch has been passed over too often.
    always_comb begin
        any_req   = if_req_i | d_req_i;
        pick_data = d_req_i;
`ifdef MEM_ARB_ANTI_STARVE_EN
        if (if_req_i && (starve_q >= STARVE_LIM)) begin
            pick_data = 1'b0;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)      state_d = REQ;
            REQ:     if (mem_gnt_i)    state_d = RESP;
            RESP:    if (mem_rvalid_i) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner and bus payload are captured once at arbitration and held for the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= OWNER_FETCH;
            mem_req_o   <= 1'b0;
            mem_adr_o   <= '0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            mem_size_o  <= '0;
        end else begin
            mem_req_o <= (state_d == REQ);
            if ((state_q == IDLE) && any_req) begin
                owner_q <= pick_data;
                if (pick_data) begin
                    mem_adr_o   <= d_adr_i;
                    mem_we_o    <= d_we_i;
                    mem_wdata_o <= d_wdata_i;
                    mem_size_o  <= d_size_i;
                end else begin
                    mem_adr_o   <= if_adr_i;
                    mem_we_o    <= 1'b0;
                    mem_wdata_o <= '0;
                    mem_size_o  <= FETCH_SIZE;
                end
            end
        end
    end

    // Drop flag: a redirect during an in-flight fetch discards that fetch's response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= 1'b0;
        end else if (state_d == IDLE) begin
            drop_q <= 1'b0;
        end else if ((state_q != IDLE) && (owner_q == OWNER_FETCH) && flush_i) begin
            drop_q <= 1'b1;
        end
    end

`ifdef MEM_ARB_ANTI_STARVE_EN
    // Saturating count of data grants taken while fetch was waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 3'd0;
        end else if ((state_q == IDLE) && any_req && !if_req_i) begin
            starve_q <= 3'd0;
        end else if (bus_gnt_c) begin
            if (owner_q == OWNER_FETCH) begin
                starve_q <= 3'd0;
            end else if (if_req_i && (starve_q != 3'd7)) begin
                starve_q <= starve_q + 3'd1;
            end
        end
    end
`endif

    // Grant and response are forwarded to the owner in the same cycle they occur on the bus.
    assign bus_gnt_c   = (state_q == REQ) && mem_gnt_i;
    assign bus_rsp_c   = (state_q == RESP) && mem_rvalid_i;

    assign if_gnt_o    = bus_gnt_c && (owner_q == OWNER_FETCH);
    assign d_gnt_o     = bus_gnt_c && (owner_q == OWNER_DATA);
    assign if_rvalid_o = bus_rsp_c && (owner_q == OWNER_FETCH) && !drop_q && !flush_i;
    assign d_rvalid_o  = bus_rsp_c && (owner_q == OWNER_DATA);

    // Read data is zero outside a valid response so idle outputs stay quiet.
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i[31:0] : 32'h0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a
// transaction-level reference model (owner, payload, lifecycle phase, drop, starve count).
module tb_mem_arbiter;

    localparam int unsigned XLEN       = 32;
    localparam int          STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req_i;
    logic [XLEN-1:0] if_adr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [31:0]     if_rdata_o;
    logic            flush_i;
    logic            d_req_i;
    logic [XLEN-1:0] d_adr_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_wdata_i;
    logic [2:0]      d_size_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_adr_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [2:0]      mem_size_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
        .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
        .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        is_data;
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
        logic [2:0]  size;
    } txn_t;

    // Requester side
    logic        f_pend, d_pend;
    logic [31:0] f_adr, d_adr, d_wdata;
    logic        d_we;
    logic [2:0]  d_size;
    // Memory side
    int          gnt_wait, rv_wait, gcnt, rcnt;
    logic        m_out, rand_mem;
    logic [31:0] rdata_next;
    // Reference model
    txn_t        cur;
    int          phase;      // 0: bus free, 1: awaiting grant, 2: awaiting response
    logic        drop;
    int          starve;
    // Observation
    int          cyc;
    int          gnt_log[$];
    logic [31:0] adr_log[$];
    int          t_if_gnt, t_if_rv, t_d_rv;
    int          n_if_rv, n_d_rv, n_d_gnt, n_req_hi;
    logic [31:0] last_if_rdata;

    task automatic cycle();
        logic eg_if, eg_d, er_if, er_d, pick_d, flush_now;
        if_req_i     = f_pend;
        if_adr_i     = f_adr;
        d_req_i      = d_pend;
        d_adr_i      = d_adr;
        d_we_i       = d_we;
        d_wdata_i    = d_wdata;
        d_size_i     = d_size;
        mem_gnt_i    = mem_req_o && (gcnt == 0);
        mem_rvalid_i = m_out && (rcnt == 0);
        mem_rdata_i  = rdata_next;
        #1;
        if (reset) begin
            chk("rst_mem_req", 32'(mem_req_o), 32'd0);
            chk("rst_mem_adr", mem_adr_o, 32'd0);
            chk("rst_mem_we", 32'(mem_we_o), 32'd0);
            chk("rst_mem_wdata", mem_wdata_o, 32'd0);
            chk("rst_mem_size", 32'(mem_size_o), 32'd0);
            chk("rst_gnts", {30'd0, if_gnt_o, d_gnt_o}, 32'd0);
            chk("rst_rvalids", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
            chk("rst_rdata", if_rdata_o | d_rdata_o, 32'd0);
            phase  = 0;
            drop   = 1'b0;
            starve = 0;
            f_pend = 1'b0;
            d_pend = 1'b0;
        end else begin
            eg_if = (phase == 1) && mem_gnt_i && !cur.is_data;
            eg_d  = (phase == 1) && mem_gnt_i && cur.is_data;
            er_if = (phase == 2) && mem_rvalid_i && !cur.is_data && !drop && !flush_i;
            er_d  = (phase == 2) && mem_rvalid_i && cur.is_data;
            chk("mem_req", 32'(mem_req_o), 32'(phase == 1));
            if (phase == 1) begin
                chk("mem_adr", mem_adr_o, cur.adr);
                chk("mem_we", 32'(mem_we_o), 32'(cur.we));
                chk("mem_size", 32'(mem_size_o), 32'(cur.size));
                if (cur.we) chk("mem_wdata", mem_wdata_o, cur.wdata);
            end
            chk("if_gnt", 32'(if_gnt_o), 32'(eg_if));
            chk("d_gnt", 32'(d_gnt_o), 32'(eg_d));
            chk("if_rvalid", 32'(if_rvalid_o), 32'(er_if));
            chk("d_rvalid", 32'(d_rvalid_o), 32'(er_d));
            if (er_if) chk("if_rdata", if_rdata_o, rdata_next);
            if (er_d && !cur.we) chk("d_rdata", d_rdata_o, rdata_next);

            // Transaction lifecycle
            flush_now = (phase != 0) && !cur.is_data && flush_i;
            case (phase)
                0: if (f_pend || d_pend) begin
                    pick_d = d_pend;
`ifdef MEM_ARB_ANTI_STARVE_EN
                    if (f_pend && starve >= STARVE_MAX) pick_d = 1'b0;
`endif
                    if (!f_pend) starve = 0;
                    cur   = pick_d ? '{1'b1, d_adr, d_we, d_wdata, d_size}
                                   : '{1'b0, f_adr, 1'b0, 32'd0, 3'b010};
                    phase = 1;
                end
                1: if (mem_gnt_i) begin
                    phase = 2;
                    if (cur.is_data) begin
                        d_pend = 1'b0;
                        if (f_pend) starve = (starve < 7) ? starve + 1 : 7;
                    end else begin
                        f_pend = 1'b0;
                        starve = 0;
                    end
                end
                default: if (mem_rvalid_i) phase = 0;
            endcase
            if (phase == 0) drop = 1'b0;
            else if (flush_now) drop = 1'b1;
        end

        // Observations of DUT outputs
        if (if_gnt_o) begin gnt_log.push_back(0); t_if_gnt = cyc; end
        if (d_gnt_o) begin gnt_log.push_back(1); n_d_gnt++; end
        if (mem_req_o && mem_gnt_i) adr_log.push_back(mem_adr_o);
        if (if_rvalid_o) begin t_if_rv = cyc; n_if_rv++; last_if_rdata = if_rdata_o; end
        if (d_rvalid_o) begin t_d_rv = cyc; n_d_rv++; end
        if (mem_req_o) n_req_hi++;

        // Memory responder
        if (mem_gnt_i) begin
            m_out = 1'b1;
            rcnt  = rv_wait;
            gcnt  = gnt_wait;
        end else begin
            if (mem_req_o && gcnt > 0) gcnt--;
            if (mem_rvalid_i) m_out = 1'b0;
            else if (m_out && rcnt > 0) rcnt--;
        end
        if (rand_mem) begin
            gnt_wait   = $urandom_range(0, 2);
            rv_wait    = $urandom_range(0, 2);
            rdata_next = $urandom;
            if (mem_gnt_i) gcnt = gnt_wait;
        end
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic clr_obs();
        gnt_log.delete();
        adr_log.delete();
        t_if_gnt = -1; t_if_rv = -1; t_d_rv = -1;
        n_if_rv = 0; n_d_rv = 0; n_d_gnt = 0; n_req_hi = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1; flush_i = 1'b0;
        f_pend = 1'b0; d_pend = 1'b0; f_adr = 32'd0; d_adr = 32'd0;
        d_we = 1'b0; d_wdata = 32'd0; d_size = 3'd0;
        gnt_wait = 0; rv_wait = 0; gcnt = 0; rcnt = 0; m_out = 1'b0;
        rand_mem = 1'b0; rdata_next = 32'h0000_0013;
        phase = 0; drop = 1'b0; starve = 0; cyc = 0; last_if_rdata = 32'd0;
        cur = '0;
        clr_obs();
        @(negedge clk); #1;
        run(2);
        reset = 1'b0;
        run(1);

        // Single fetch with immediate grant and response
        clr_obs();
        f_pend = 1'b1; f_adr = 32'h80; t0 = cyc;
        run(4);
        chk("fetch_gnt_cycle", 32'(t_if_gnt - t0), 32'd1);
        chk("fetch_rv_cycle", 32'(t_if_rv - t0), 32'd2);
        chk("fetch_rdata", last_if_rdata, 32'h0000_0013);
        chk("fetch_req_cycles", 32'(n_req_hi), 32'd1);

        // Contention: load first, then fetch
        clr_obs();
        f_pend = 1'b1; f_adr = 32'h80;
        d_pend = 1'b1; d_adr = 32'h1000; d_we = 1'b0; d_size = 3'b010;
        run(8);
        chk("cont_adr0", adr_log[0], 32'h1000);
        chk("cont_adr1", adr_log[1], 32'h80);
        chk("cont_fetch_after_load", 32'(t_if_gnt > t_d_rv), 32'd1);

        // Store with three stalled grant cycles
        clr_obs();
        gnt_wait = 3; gcnt = 3;
        d_pend = 1'b1; d_adr = 32'h2000; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_size = 3'b010;
        run(8);
        chk("store_req_cycles", 32'(n_req_hi), 32'd4);
        chk("store_gnt_pulses", 32'(n_d_gnt), 32'd1);
        chk("store_rv_pulses", 32'(n_d_rv), 32'd1);
        gnt_wait = 0; gcnt = 0; d_we = 1'b0;

        // Flush during response wait drops the fetch response
        clr_obs();
        rv_wait = 2;
        f_pend = 1'b1; f_adr = 32'h84;
        run(2);
        flush_i = 1'b1;
        run(1);
        flush_i = 1'b0;
        run(3);
        chk("flush_drop", 32'(n_if_rv), 32'd0);
        rv_wait = 0;
        f_pend = 1'b1; f_adr = 32'h88;
        run(4);
        chk("flush_next_fetch", 32'(n_if_rv), 32'd1);

        // Reset while awaiting a response; the late response is ignored
        clr_obs();
        rv_wait = 3;
        f_pend = 1'b1; f_adr = 32'h90;
        run(3);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(4);
        chk("rst_mid_rvalids", 32'(n_if_rv + n_d_rv), 32'd0);
        chk("rst_mid_idle_adr", mem_adr_o, 32'd0);
        chk("rst_mid_mem_out", 32'(m_out), 32'd0);
        rv_wait = 0;

        // Continuous contention: grant order
        clr_obs();
        d_adr = 32'h3000;
        for (int i = 0; i < 40; i++) begin
            f_pend = 1'b1;
            d_pend = 1'b1;
            cycle();
        end
        chk("starve_len", 32'(gnt_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_ANTI_STARVE_EN
            chk($sformatf("starve_grant%0d", i), 32'(gnt_log[i]), (i == 4) ? 32'd0 : 32'd1);
`else
            chk($sformatf("strict_grant%0d", i), 32'(gnt_log[i]), 32'd1);
`endif
        end
        d_pend = 1'b0;
        for (int i = 0; i < 100 && (phase != 0 || f_pend); i++) cycle();

        // Randomized traffic
        rand_mem = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1'b1; f_adr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; d_adr = $urandom; d_we = 1'($urandom_range(0, 1));
                d_wdata = $urandom; d_size = 3'($urandom_range(0, 2));
            end
            flush_i = ($urandom_range(0, 7) == 0);
            cycle();
        end
        flush_i = 1'b0;
        for (int i = 0; i < 200 && (phase != 0 || f_pend || d_pend); i++) cycle();
        chk("drain", 32'(phase != 0 || f_pend || d_pend), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
